ones_frame_stats: RTL and testbench
===================================

Name: ones_frame_stats

Overview:
- Downstream consumer of the combinational ones-counter.
- Takes one 5-bit ones-count per accepted 16-bit word over a valid/ready handshake.
- Accumulates statistics over a fixed frame of FRAME_LEN words, then presents a registered frame summary through a second valid/ready handshake.
- Summary fields: total ones, max/min per-word count, number of all-zero words and an illegal-input flag.

Parameters:
- FRAME_LEN, default 8: words per frame; legal range 2..15.
- SUM_W, default 8: SUM width; must satisfy 2^SUM_W > 16*FRAME_LEN.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear; discards the partial frame and any held result.
- IN_VALID  input  1  NUMBER is valid this cycle.
- IN_READY  output  1  block can accept NUMBER this cycle.
- NUMBER  input  5  ones count of one 16-bit word; legal values 0..16.
- OUT_VALID  output  1  frame summary valid.
- OUT_READY  input  1  consumer accepts the summary.
- SUM  output  SUM_W  total ones in the frame.
- MAX  output  5  largest per-word count in the frame.
- MIN  output  5  smallest per-word count in the frame.
- ZEROS  output  4  number of words with count 0.
- ERR  output  1  at least one NUMBER > 16 occurred in the frame.

Behaviour:
- Reset and clocking: one clock, CLK. RST_N is asynchronous, active-low.
- Reset state:
  - state ACCUM, word index 0.
  - OUT_VALID=0; SUM, MAX, MIN, ZEROS, ERR all 0.
  - Running accumulators cleared; running min preset to 16.
  - IN_READY=1 once RST_N is deasserted.
- Accept rule:
  - A word is accepted on a rising edge where IN_VALID=1 and IN_READY=1.
  - Cycles with IN_VALID=0 change nothing.
- IN_READY is combinational from state: 1 in ACCUM, 0 in HOLD. It never depends on IN_VALID.
- Per accepted word, with value n = min(NUMBER, 16):
  - sum += n.
  - max = larger of max and n; min = smaller of min and n.
  - zeros += (n==0).
  - err |= (NUMBER > 16).
  - index += 1.
- State ACCUM:
  - If the accepted word has index == FRAME_LEN-1, the frame is complete.
  - The next edge loads the summary registers, including this last word.
  - Same edge: OUT_VALID goes 1, state goes HOLD, index returns to 0, running accumulators reset (min preset to 16).
  - Latency: last word accepted at edge t, OUT_VALID=1 and summary visible after edge t.
- State HOLD:
  - Summary outputs and OUT_VALID are held stable; IN_READY=0.
  - When OUT_READY=1 at an edge: OUT_VALID goes 0 and state goes ACCUM. Summary registers keep their last value.
  - A new word can be accepted on the first cycle after the handshake.
  - Minimum frame-to-frame spacing is FRAME_LEN+1 cycles.
- OUT_READY is ignored while OUT_VALID=0.
- CLR, synchronous, highest priority over every handshake in the same cycle:
  - state goes ACCUM, index 0, running accumulators reset.
  - OUT_VALID goes 0, summary registers go 0.
  - A word presented in the same cycle is NOT accepted.
- Reset mid-frame: partial frame lost; behaviour identical to power-on reset.
- Width and arithmetic:
  - No internal overflow: SUM_W is sized by parameter.
  - ZEROS ≤ FRAME_LEN ≤ 15.
  - MIN/MAX are always in 0..16.
- An illegal NUMBER (17..31) is clamped to 16 for all statistics and sets ERR for that frame only.

Test Plan:
- Reset behaviour: RST_N low for 3 cycles, then high -> OUT_VALID=0, SUM=MAX=MIN=ZEROS=0, ERR=0, IN_READY=1.
  - Repeat the reset after 2 of 4 words; a fresh frame then behaves as if the first 2 words never existed.
- Basic frame (FRAME_LEN=4): words 3,16,0,7 back-to-back -> after the 4th accept edge OUT_VALID=1 with SUM=26, MAX=16, MIN=0, ZEROS=1, ERR=0.
- Backpressure: same frame with OUT_READY=0 for 5 cycles while IN_VALID=1 with NUMBER=9 -> IN_READY=0 and outputs frozen throughout.
  - After OUT_READY=1, OUT_VALID drops the next edge.
  - The waiting 9 is accepted as word 0 of the next frame, not before.
- Input gaps (FRAME_LEN=4): words 5,_,_,5,_,5,5 with IN_VALID low on the gaps -> SUM=20, MAX=MIN=5, ZEROS=0; gaps not counted.
- Illegal input (FRAME_LEN=4): words 20,1,2,3 -> SUM=22, MAX=16, MIN=1, ERR=1.
  - Next frame 1,1,1,1 -> SUM=4, ERR=0.
- CLR mid-frame (FRAME_LEN=4): accept 8,8, then CLR with IN_VALID=1 and NUMBER=8 -> that word is not accepted.
  - Following frame 1,1,1,1 -> SUM=4, ZEROS=0.
  - CLR while in HOLD -> OUT_VALID=0 and SUM=0 next edge.
- Full-scale frame (FRAME_LEN=15, SUM_W=8): fifteen words of 16 -> SUM=240, MIN=MAX=16.
  - Fifteen words of 0 -> ZEROS=15, SUM=0.

Source files
------------

// File: rtl/ones_frame_stats.sv
// Per-frame statistics over a stream of 5-bit ones-counts: total, max, min,
// zero-word count and an illegal-input flag, presented over a valid/ready handshake.
module ones_frame_stats #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum,
    output logic [4:0]       max,
    output logic [4:0]       min,
    output logic [3:0]       zeros,
    output logic             err
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    function automatic logic [4:0] clamp16(input logic [4:0] v);
        return (v > 5'd16) ? 5'd16 : v;
    endfunction

    logic [0:0]       state;
    logic [3:0]       idx;
    logic [SUM_W-1:0] acc_sum;
    logic [4:0]       acc_max;
    logic [4:0]       acc_min;
    logic [3:0]       acc_zeros;
    logic             acc_err;

    logic [4:0]       n_p0;
    logic             accept;
    logic             last;
    logic [SUM_W-1:0] nxt_sum;
    logic [4:0]       nxt_max;
    logic [4:0]       nxt_min;
    logic [3:0]       nxt_zeros;
    logic             nxt_err;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign last     = (idx == 4'(FRAME_LEN - 1));

    // Stage 0: clamp the incoming count and fold it into the running statistics
    always_comb begin
        n_p0      = clamp16(number);
        nxt_sum   = acc_sum + SUM_W'(n_p0);
        nxt_max   = (n_p0 > acc_max) ? n_p0 : acc_max;
        nxt_min   = (n_p0 < acc_min) ? n_p0 : acc_min;
        nxt_zeros = acc_zeros + {3'b000, (n_p0 == 5'd0)};
        nxt_err   = acc_err | (number > 5'd16);
    end

    // Stage 1: running accumulators and registered frame summary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            idx       <= '0;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_min   <= 5'd16;
            acc_zeros <= '0;
            acc_err   <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            max       <= '0;
            min       <= '0;
            zeros     <= '0;
            err       <= 1'b0;
        end else if (clr) begin
            state     <= ACCUM;
            idx       <= '0;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_min   <= 5'd16;
            acc_zeros <= '0;
            acc_err   <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            max       <= '0;
            min       <= '0;
            zeros     <= '0;
            err       <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                if (last) begin
                    // Last word goes straight into the summary; accumulators restart
                    sum       <= nxt_sum;
                    max       <= nxt_max;
                    min       <= nxt_min;
                    zeros     <= nxt_zeros;
                    err       <= nxt_err;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                    idx       <= '0;
                    acc_sum   <= '0;
                    acc_max   <= '0;
                    acc_min   <= 5'd16;
                    acc_zeros <= '0;
                    acc_err   <= 1'b0;
                end else begin
                    acc_sum   <= nxt_sum;
                    acc_max   <= nxt_max;
                    acc_min   <= nxt_min;
                    acc_zeros <= nxt_zeros;
                    acc_err   <= nxt_err;
                    idx       <= idx + 4'd1;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
        end
    end

endmodule

// File: tb/tb_ones_frame_stats.sv
// Bench for ones_frame_stats: reference model feeds a scoreboard of frame summaries,
// plus a second instance exercising the full-scale 15-word frame.
module tb_ones_frame_stats;

    typedef struct {
        int sum;
        int mx;
        int mn;
        int zeros;
        int err;
    } summ_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] number = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic [4:0] max;
    logic [4:0] min;
    logic [3:0] zeros;
    logic       err;

    logic       b_clr = 1'b0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [4:0] b_number = '0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [7:0] b_sum;
    logic [4:0] b_max;
    logic [4:0] b_min;
    logic [3:0] b_zeros;
    logic       b_err;

    int n_tests = 0;
    int n_fail  = 0;

    summ_t exp_q[$];
    int    m_hold, m_idx, m_sum, m_max, m_min, m_zeros, m_err;
    int    o_valid, o_sum, o_max, o_min, o_zeros, o_err;
    bit    seen;

    always #5 clk = ~clk;

    ones_frame_stats #(.FRAME_LEN(4), .SUM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .number(number),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .max(max), .min(min), .zeros(zeros), .err(err)
    );

    ones_frame_stats #(.FRAME_LEN(15), .SUM_W(8)) dut_full (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .number(b_number),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum(b_sum), .max(b_max), .min(b_min), .zeros(b_zeros), .err(b_err)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset(input bit outs);
        m_hold = 0; m_idx = 0; m_sum = 0; m_max = 0; m_min = 16; m_zeros = 0; m_err = 0;
        if (outs) begin
            m_hold = 0; o_valid = 0;
            o_sum = 0; o_max = 0; o_min = 0; o_zeros = 0; o_err = 0;
        end
    endtask

    // Expected effect of the coming clock edge, from the inputs alone
    task automatic model_edge(input bit v, input int num, input bit ordy, input bit c);
        int n;
        if (c) begin
            model_reset(1);
        end else if (m_hold == 0) begin
            if (v) begin
                n = (num > 16) ? 16 : num;
                m_sum += n;
                if (n > m_max) m_max = n;
                if (n < m_min) m_min = n;
                if (n == 0) m_zeros++;
                if (num > 16) m_err = 1;
                m_idx++;
                if (m_idx == 4) begin
                    o_sum = m_sum; o_max = m_max; o_min = m_min;
                    o_zeros = m_zeros; o_err = m_err; o_valid = 1;
                    exp_q.push_back('{sum: m_sum, mx: m_max, mn: m_min, zeros: m_zeros, err: m_err});
                    model_reset(0);
                    m_hold = 1;
                end
            end
        end else if (ordy) begin
            m_hold = 0;
            o_valid = 0;
        end
    endtask

    task automatic step(input bit v, input int num, input bit ordy, input bit c);
        summ_t e;
        in_valid = v; number = 5'(num); out_ready = ordy; clr = c;
        model_edge(v, num, ordy, c);
        @(posedge clk);
        #1;
        chk("in_ready", int'(in_ready), (m_hold == 0) ? 1 : 0);
        chk("out_valid", int'(out_valid), o_valid);
        chk("sum_reg", int'(sum), o_sum);
        chk("max_reg", int'(max), o_max);
        chk("min_reg", int'(min), o_min);
        chk("zeros_reg", int'(zeros), o_zeros);
        chk("err_reg", int'(err), o_err);
        if (out_valid && !seen) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_frame", int'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum", int'(sum), e.sum);
                chk("sb_max", int'(max), e.mx);
                chk("sb_min", int'(min), e.mn);
                chk("sb_zeros", int'(zeros), e.zeros);
                chk("sb_err", int'(err), e.err);
            end
        end
        seen = out_valid;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; number = '0;
        model_reset(1);
        seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_max", int'(max), 0);
        chk("rst_min", int'(min), 0);
        chk("rst_zeros", int'(zeros), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    task automatic step_b(input bit v, input int num, input bit ordy);
        b_in_valid = v; b_number = 5'(num); b_out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Two words of a frame, then reset: they must vanish
        step(1, 3, 0, 0);
        step(1, 16, 0, 0);
        do_reset();

        // Basic frame, then backpressure with a waiting 9
        step(1, 3, 0, 0);
        step(1, 16, 0, 0);
        step(1, 0, 0, 0);
        step(1, 7, 0, 0);
        chk("basic_valid", int'(out_valid), 1);
        chk("basic_sum", int'(sum), 26);
        chk("basic_max", int'(max), 16);
        chk("basic_min", int'(min), 0);
        chk("basic_zeros", int'(zeros), 1);
        chk("basic_err", int'(err), 0);
        repeat (5) begin
            step(1, 9, 0, 0);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_sum_frozen", int'(sum), 26);
        end
        step(1, 9, 1, 0);
        chk("bp_release", int'(out_valid), 0);
        step(1, 9, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("bp_next_sum", int'(sum), 12);
        chk("bp_next_max", int'(max), 9);
        step(0, 0, 1, 0);

        // Gaps on the input are not counted
        step(1, 5, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 5, 0, 0);
        step(0, 0, 0, 0);
        step(1, 5, 0, 0);
        step(1, 5, 0, 0);
        chk("gap_sum", int'(sum), 20);
        chk("gap_max", int'(max), 5);
        chk("gap_min", int'(min), 5);
        chk("gap_zeros", int'(zeros), 0);
        step(0, 0, 1, 0);

        // Illegal input clamps and flags only its own frame
        step(1, 20, 0, 0);
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        chk("ill_sum", int'(sum), 22);
        chk("ill_max", int'(max), 16);
        chk("ill_min", int'(min), 1);
        chk("ill_err", int'(err), 1);
        step(0, 0, 1, 0);
        repeat (4) step(1, 1, 0, 0);
        chk("post_ill_sum", int'(sum), 4);
        chk("post_ill_err", int'(err), 0);
        step(0, 0, 1, 0);

        // CLR mid-frame drops the partial frame and the same-cycle word
        step(1, 8, 0, 0);
        step(1, 8, 0, 0);
        step(1, 8, 0, 1);
        repeat (4) step(1, 1, 0, 0);
        chk("clr_sum", int'(sum), 4);
        chk("clr_zeros", int'(zeros), 0);
        chk("clr_hold_valid", int'(out_valid), 1);
        step(0, 0, 0, 1);
        chk("clr_hold_drop", int'(out_valid), 0);
        chk("clr_hold_sum", int'(sum), 0);

        // Random traffic against the model
        for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
        end
        step(0, 0, 1, 0);
        chk("sb_drain", exp_q.size(), 0);

        // Full-scale frame on the 15-word instance
        repeat (14) step_b(1, 16, 0);
        chk("full_early_valid", int'(b_out_valid), 0);
        step_b(1, 16, 0);
        chk("full_valid", int'(b_out_valid), 1);
        chk("full_sum", int'(b_sum), 240);
        chk("full_max", int'(b_max), 16);
        chk("full_min", int'(b_min), 16);
        chk("full_err", int'(b_err), 0);
        step_b(0, 0, 1);
        chk("full_release", int'(b_out_valid), 0);
        repeat (15) step_b(1, 0, 0);
        chk("zero_valid", int'(b_out_valid), 1);
        chk("zero_zeros", int'(b_zeros), 15);
        chk("zero_sum", int'(b_sum), 0);
        chk("zero_max", int'(b_max), 0);
        step_b(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
